// File: rtl/dpram64_arb.sv
// dpram64_arb: two-requester access controller for the dpram64 line RAM.
// Reads and writes are arbitrated independently (round-robin each), so one
// read and one write can issue per cycle. Read data returns one cycle after
// the grant, with same-cycle write bytes forwarded over the RAM's pre-write data.
module dpram64_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 16,
  parameter int OFF_BITS   = $clog2(DATA_WIDTH/8)
) (
  input  logic                    clk,
  input  logic                    rst,
  // requester 0
  input  logic                    req_valid_0,
  output logic                    req_ready_0,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_0,
  input  logic [ADDR_WIDTH-1:0]   req_addr_0,
  input  logic [DATA_WIDTH-1:0]   req_wdata_0,
  output logic                    rsp_valid_0,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_0,
  // requester 1
  input  logic                    req_valid_1,
  output logic                    req_ready_1,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_1,
  input  logic [ADDR_WIDTH-1:0]   req_addr_1,
  input  logic [DATA_WIDTH-1:0]   req_wdata_1,
  output logic                    rsp_valid_1,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_1,
  // RAM side
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [ADDR_WIDTH-1:0]   ram_raddr,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int LINE_BYTES = DATA_WIDTH / 8;

  // Clear the line-offset bits; the RAM only ever sees line-aligned addresses.
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    r[OFF_BITS-1:0] = {OFF_BITS{1'b0}};
    return r;
  endfunction

  // Request classification
  logic rd_req_0_s, rd_req_1_s, wr_req_0_s, wr_req_1_s;
  // Grants
  logic rd_gnt_0_s, rd_gnt_1_s, wr_gnt_0_s, wr_gnt_1_s;
  logic rd_any_s, wr_any_s;
  // Winner-selected request fields
  logic [ADDR_WIDTH-1:0] rd_addr_sel_s, wr_addr_sel_s;
  logic [LINE_BYTES-1:0] wr_strb_sel_s;
  logic [DATA_WIDTH-1:0] wr_data_sel_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] merged_s;

  // Arbitration state
  logic rd_prio_r, wr_prio_r;
  // Last driven RAM address/data, held while nothing is granted
  logic [ADDR_WIDTH-1:0] raddr_r, waddr_r;
  logic [DATA_WIDTH-1:0] din_r;
  // Response pipeline
  logic                  rsp_pend_r;
  logic                  rsp_owner_r;
  logic                  fwd_hit_r;
  logic [LINE_BYTES-1:0] fwd_strb_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;

  // Classify requests and pick winners; no grants at all while in reset.
  always_comb begin
    rd_req_0_s = req_valid_0 && ~|req_wstrb_0;
    rd_req_1_s = req_valid_1 && ~|req_wstrb_1;
    wr_req_0_s = req_valid_0 &&  |req_wstrb_0;
    wr_req_1_s = req_valid_1 &&  |req_wstrb_1;
    rd_gnt_0_s = 1'b0;
    rd_gnt_1_s = 1'b0;
    wr_gnt_0_s = 1'b0;
    wr_gnt_1_s = 1'b0;
    if (rst) begin
      rd_gnt_0_s = 1'b0;
      rd_gnt_1_s = 1'b0;
      wr_gnt_0_s = 1'b0;
      wr_gnt_1_s = 1'b0;
    end else begin
      // A lone requester always wins; under contention the prio bit picks.
      rd_gnt_0_s = rd_req_0_s && (!rd_req_1_s || (rd_prio_r == 1'b0));
      rd_gnt_1_s = rd_req_1_s && (!rd_req_0_s || (rd_prio_r == 1'b1));
      wr_gnt_0_s = wr_req_0_s && (!wr_req_1_s || (wr_prio_r == 1'b0));
      wr_gnt_1_s = wr_req_1_s && (!wr_req_0_s || (wr_prio_r == 1'b1));
    end
    rd_any_s = rd_gnt_0_s || rd_gnt_1_s;
    wr_any_s = wr_gnt_0_s || wr_gnt_1_s;
  end

  // Ready is simply "granted this cycle", in either class.
  always_comb begin
    req_ready_0 = rd_gnt_0_s || wr_gnt_0_s;
    req_ready_1 = rd_gnt_1_s || wr_gnt_1_s;
  end

  // Route the winning request's fields toward the RAM.
  always_comb begin
    if (rd_gnt_1_s) begin
      rd_addr_sel_s = line_addr(req_addr_1);
    end else begin
      rd_addr_sel_s = line_addr(req_addr_0);
    end
    if (wr_gnt_1_s) begin
      wr_addr_sel_s = line_addr(req_addr_1);
      wr_strb_sel_s = req_wstrb_1;
      wr_data_sel_s = req_wdata_1;
    end else begin
      wr_addr_sel_s = line_addr(req_addr_0);
      wr_strb_sel_s = req_wstrb_0;
      wr_data_sel_s = req_wdata_0;
    end
    // The RAM returns pre-write data on a same-line collision, so remember to patch it.
    fwd_hit_s = rd_any_s && wr_any_s && (rd_addr_sel_s == wr_addr_sel_s);
  end

  // Drive the RAM ports; addresses and data hold their last value when idle.
  always_comb begin
    if (rd_any_s) begin
      ram_raddr = rd_addr_sel_s;
    end else begin
      ram_raddr = raddr_r;
    end
    if (wr_any_s) begin
      ram_we    = wr_strb_sel_s;
      ram_waddr = wr_addr_sel_s;
      ram_din   = wr_data_sel_s;
    end else begin
      ram_we    = {LINE_BYTES{1'b0}};
      ram_waddr = waddr_r;
      ram_din   = din_r;
    end
  end

  // Round-robin priority bits: after contention, the loser gets priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prio_r <= 1'b0;
      wr_prio_r <= 1'b0;
    end else begin
      if (rd_req_0_s && rd_req_1_s) begin
        rd_prio_r <= rd_gnt_0_s;
      end else begin
        rd_prio_r <= rd_prio_r;
      end
      if (wr_req_0_s && wr_req_1_s) begin
        wr_prio_r <= wr_gnt_0_s;
      end else begin
        wr_prio_r <= wr_prio_r;
      end
    end
  end

  // Registered copies of the RAM address/data so idle cycles keep them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_r <= {ADDR_WIDTH{1'b0}};
      waddr_r <= {ADDR_WIDTH{1'b0}};
      din_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      raddr_r <= ram_raddr;
      waddr_r <= ram_waddr;
      din_r   <= ram_din;
    end
  end

  // Capture read ownership and forwarding info for the response next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_r  <= 1'b0;
      rsp_owner_r <= 1'b0;
      fwd_hit_r   <= 1'b0;
      fwd_strb_r  <= {LINE_BYTES{1'b0}};
      fwd_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_pend_r  <= rd_any_s;
      rsp_owner_r <= rd_gnt_1_s;
      fwd_hit_r   <= fwd_hit_s;
      fwd_strb_r  <= wr_strb_sel_s;
      fwd_data_r  <= wr_data_sel_s;
    end
  end

  // Merge forwarded write bytes over the RAM output, byte by byte.
  always_comb begin
    merged_s = ram_dout;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (fwd_hit_r && fwd_strb_r[b]) begin
        merged_s[b*8 +: 8] = fwd_data_r[b*8 +: 8];
      end else begin
        merged_s[b*8 +: 8] = ram_dout[b*8 +: 8];
      end
    end
  end

  // Present the response; a read caught by reset never produces a valid.
  always_comb begin
    rsp_rdata_0 = merged_s;
    rsp_rdata_1 = merged_s;
    rsp_valid_0 = rsp_pend_r && !rsp_owner_r && !rst;
    rsp_valid_1 = rsp_pend_r &&  rsp_owner_r && !rst;
  end

endmodule

// File: tb/tb_dpram64_arb.sv
// Directed bench for dpram64_arb with a behavioural line RAM, a queue of
// expected read responses, and a monitor that checks every response.
module tb_dpram64_arb;
  localparam int DW = 512;
  localparam int AW = 16;
  localparam int LB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [LB-1:0] req_wstrb_0, req_wstrb_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_rdata_0, rsp_rdata_1;
  logic [LB-1:0] ram_we;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  typedef struct { logic owner; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] mem [0:1023];

  dpram64_arb dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_wstrb_0(req_wstrb_0),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_wstrb_1(req_wstrb_1),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Line RAM model: registered read of pre-write contents, byte-masked write.
  always @(posedge clk) begin
    ram_dout <= mem[ram_raddr[AW-1:6]];
    for (int b = 0; b < LB; b++) begin
      if (ram_we[b]) mem[ram_waddr[AW-1:6]][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  function automatic logic [DW-1:0] fill(input logic [7:0] v);
    return {LB{v}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set0(input logic v, input logic [LB-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_0 = v; req_wstrb_0 = s; req_addr_0 = a; req_wdata_0 = d;
  endtask

  task automatic set1(input logic v, input logic [LB-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_1 = v; req_wstrb_1 = s; req_addr_1 = a; req_wdata_1 = d;
  endtask

  task automatic idle();
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
  endtask

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string n, input logic e0, input logic e1);
    check({n, "_ready0"}, DW'(req_ready_0), DW'(e0));
    check({n, "_ready1"}, DW'(req_ready_1), DW'(e1));
  endtask

  task automatic push(input logic owner, input logic [DW-1:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Response monitor: every valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid_0 || rsp_valid_1) begin
      if (rsp_valid_0 && rsp_valid_1) begin
        check("rsp_both_valid", 1, 0);
      end else if (exp_q.size() == 0) begin
        check("rsp_unexpected", DW'(rsp_valid_1), DW'(2));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", DW'(rsp_valid_1), DW'(e.owner));
        check("rsp_rdata_0", rsp_rdata_0, e.data);
        check("rsp_rdata_1", rsp_rdata_1, e.data);
      end
    end
  end

  initial begin
    logic [DW-1:0] d3, exp3;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[1] = fill(8'hA1);
    mem[2] = fill(8'h11);
    mem[3] = fill(8'hC3);
    mem[4] = fill(8'h44);
    mem[5] = fill(8'h55);
    d3 = '0;
    d3[31:0] = 32'hDEADBEEF;
    exp3 = fill(8'h11);
    exp3[31:0] = 32'hDEADBEEF;

    // Reset: requests present but nothing may be granted or written.
    rst = 1'b1;
    set0(1'b1, '0, 16'h0040, '0);
    set1(1'b1, '1, 16'h0080, fill(8'hEE));
    cyc(); cyc(); #1;
    chk_rdy("reset", 1'b0, 1'b0);
    check("reset_we", DW'(ram_we), '0);
    check("reset_rsp_valid", DW'({rsp_valid_0, rsp_valid_1}), '0);
    check("reset_raddr", DW'(ram_raddr), '0);
    check("reset_waddr", DW'(ram_waddr), '0);
    idle();
    cyc();
    rst = 1'b0;

    // Single read of line 1.
    cyc(); set0(1'b1, '0, 16'h0040, '0); #1;
    chk_rdy("rd_single", 1'b1, 1'b0);
    check("rd_single_raddr", DW'(ram_raddr), DW'(16'h0040));
    check("rd_single_we", DW'(ram_we), '0);
    push(1'b0, fill(8'hA1));
    cyc(); idle(); #1;
    check("idle_raddr_hold", DW'(ram_raddr), DW'(16'h0040));

    // Back-to-back read contention: grants alternate 0,1,0,1 then R0 alone.
    cyc(); set0(1'b1, '0, 16'h0040, '0); set1(1'b1, '0, 16'h0080, '0); #1;
    chk_rdy("rr0", 1'b1, 1'b0);
    check("rr0_raddr", DW'(ram_raddr), DW'(16'h0040));
    push(1'b0, fill(8'hA1));
    cyc(); set0(1'b1, '0, 16'h00C0, '0); #1;
    chk_rdy("rr1", 1'b0, 1'b1);
    check("rr1_raddr", DW'(ram_raddr), DW'(16'h0080));
    push(1'b1, fill(8'h11));
    cyc(); set1(1'b1, '0, 16'h0140, '0); #1;
    chk_rdy("rr2", 1'b1, 1'b0);
    check("rr2_raddr", DW'(ram_raddr), DW'(16'h00C0));
    push(1'b0, fill(8'hC3));
    cyc(); set0(1'b1, '0, 16'h0100, '0); #1;
    chk_rdy("rr3", 1'b0, 1'b1);
    check("rr3_raddr", DW'(ram_raddr), DW'(16'h0140));
    push(1'b1, fill(8'h55));
    cyc(); set1(1'b0, '0, '0, '0); #1;
    chk_rdy("rr4", 1'b1, 1'b0);
    push(1'b0, fill(8'h44));
    cyc(); idle();

    // Unaligned read address is truncated to the line.
    cyc(); set0(1'b1, '0, 16'h00C7, '0); #1;
    chk_rdy("unaligned", 1'b1, 1'b0);
    check("unaligned_raddr", DW'(ram_raddr), DW'(16'h00C0));
    push(1'b0, fill(8'hC3));
    cyc(); idle();

    // Same-line write + read in one cycle: forwarded bytes 0-3.
    cyc(); set0(1'b1, 64'hF, 16'h0080, d3); set1(1'b1, '0, 16'h0080, '0); #1;
    chk_rdy("fwd", 1'b1, 1'b1);
    check("fwd_we", DW'(ram_we), DW'(64'hF));
    check("fwd_waddr", DW'(ram_waddr), DW'(16'h0080));
    check("fwd_raddr", DW'(ram_raddr), DW'(16'h0080));
    check("fwd_din", ram_din, d3);
    push(1'b1, exp3);
    // Read the next cycle sees the write through the RAM.
    cyc(); idle(); set0(1'b1, '0, 16'h0080, '0); #1;
    chk_rdy("after_wr", 1'b1, 1'b0);
    push(1'b0, exp3);
    // A read at T does not see a write to the same line at T+1.
    cyc(); idle(); set1(1'b1, '0, 16'h0040, '0); #1;
    chk_rdy("rd_before_wr", 1'b0, 1'b1);
    push(1'b1, fill(8'hA1));
    cyc(); idle(); set0(1'b1, '1, 16'h0040, fill(8'h77)); #1;
    chk_rdy("wr_after_rd", 1'b1, 1'b0);
    cyc(); idle();

    // Write contention: winners alternate, later write wins in the RAM.
    cyc(); set0(1'b1, '1, 16'h0100, fill(8'hA0)); set1(1'b1, '1, 16'h0100, fill(8'hB0)); #1;
    chk_rdy("ww0", 1'b1, 1'b0);
    check("ww0_din", ram_din, fill(8'hA0));
    cyc(); set0(1'b1, '1, 16'h0140, fill(8'hA5)); #1;
    chk_rdy("ww1", 1'b0, 1'b1);
    check("ww1_din", ram_din, fill(8'hB0));
    check("ww1_waddr", DW'(ram_waddr), DW'(16'h0100));
    cyc(); set1(1'b1, '1, 16'h0140, fill(8'hB5)); #1;
    chk_rdy("ww2", 1'b1, 1'b0);
    check("ww2_din", ram_din, fill(8'hA5));
    cyc(); set0(1'b0, '0, '0, '0); #1;
    chk_rdy("ww3", 1'b0, 1'b1);
    check("ww3_din", ram_din, fill(8'hB5));
    cyc(); idle(); set0(1'b1, '0, 16'h0100, '0); #1;
    push(1'b0, fill(8'hB0));
    cyc(); idle(); set1(1'b1, '0, 16'h0140, '0); #1;
    push(1'b1, fill(8'hB5));

    // Leave rd_prio = 1 and wr_prio = 1, then a read caught by reset.
    cyc(); set0(1'b1, '0, 16'h0040, '0); set1(1'b1, '0, 16'h0080, '0); #1;
    chk_rdy("pre_rst", 1'b1, 1'b0);
    push(1'b0, fill(8'h77));
    cyc(); set0(1'b0, '0, '0, '0); #1;
    chk_rdy("rd_lost", 1'b0, 1'b1);
    cyc(); rst = 1'b1;
    set0(1'b1, '1, 16'h0040, fill(8'h99)); set1(1'b1, '0, 16'h0040, '0); #1;
    chk_rdy("in_rst", 1'b0, 1'b0);
    check("in_rst_we", DW'(ram_we), '0);
    check("in_rst_rsp_valid1", DW'(rsp_valid_1), '0);
    cyc(); idle(); #1;
    check("in_rst_rsp_valid", DW'({rsp_valid_0, rsp_valid_1}), '0);
    cyc(); rst = 1'b0;

    // Priorities cleared: requester 0 wins first contention in both classes.
    set0(1'b1, '0, 16'h0040, '0); set1(1'b1, '0, 16'h0080, '0); #1;
    chk_rdy("post_rst_rd", 1'b1, 1'b0);
    push(1'b0, fill(8'h77));
    cyc(); set0(1'b0, '0, '0, '0); #1;
    chk_rdy("post_rst_rd1", 1'b0, 1'b1);
    push(1'b1, exp3);
    cyc(); set0(1'b1, '1, 16'h0180, fill(8'h66)); set1(1'b1, '1, 16'h01C0, fill(8'h67)); #1;
    chk_rdy("post_rst_wr", 1'b1, 1'b0);
    check("post_rst_wr_waddr", DW'(ram_waddr), DW'(16'h0180));
    cyc(); set0(1'b0, '0, '0, '0); #1;
    chk_rdy("post_rst_wr1", 1'b0, 1'b1);
    cyc(); idle();

    repeat (4) cyc();
    check("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpram64_arb.md
Name: dpram64_arb

Overview:
- Two-requester access controller for the dpram64 line RAM: one read port, one byte-masked write port, both LINE_BYTES wide.
- Arbitrates each RAM port independently with round-robin priority, so one read and one write can issue in the same cycle.
- Returns read data with fixed 1-cycle latency.
- Forwards same-cycle write bytes into read responses, because the RAM returns pre-write data on a same-line read/write collision.
- Sits between core-side masters (fetch/LSU or AXI slave shim) and the RAM instance.

Parameters:
DATA_WIDTH, 512, line width in bits; LINE_BYTES = DATA_WIDTH/8
ADDR_WIDTH, 16, byte address width; matches the RAM index width
OFF_BITS, $clog2(DATA_WIDTH/8), line-offset bits; forced to zero toward the RAM

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_0  in  1  requester 0 request valid
req_ready_0  out  1  requester 0 accepted this cycle
req_wstrb_0  in  LINE_BYTES  byte write mask; all-zero = read
req_addr_0  in  ADDR_WIDTH  byte address; low OFF_BITS ignored
req_wdata_0  in  DATA_WIDTH  write data
rsp_valid_0  out  1  read data valid for requester 0
rsp_rdata_0  out  DATA_WIDTH  read data
req_valid_1/req_ready_1/req_wstrb_1/req_addr_1/req_wdata_1/rsp_valid_1/rsp_rdata_1  same as requester 0, for requester 1
ram_we  out  LINE_BYTES  to RAM we
ram_din  out  DATA_WIDTH  to RAM din
ram_waddr  out  ADDR_WIDTH  to RAM waddr; low OFF_BITS = 0
ram_raddr  out  ADDR_WIDTH  to RAM raddr; low OFF_BITS = 0
ram_dout  in  DATA_WIDTH  from RAM dout; registered, valid the cycle after raddr

Behaviour:
- Request classification:
  - Write: req_valid_i && |req_wstrb_i.
  - Read: req_valid_i && ~|req_wstrb_i.
- Handshake:
  - A request is accepted in cycle T iff req_valid_i && req_ready_i.
  - req_ready_i is combinational from this cycle's grants.
  - Requesters hold all req_* stable until accepted.
  - No response backpressure; the requester must take rsp_* on the cycle it is valid.
- Read arbitration (state rd_prio, 1 bit):
  - One reader: it is granted.
  - Two readers: requester rd_prio is granted, then rd_prio <= ~winner.
  - rd_prio is unchanged when there is no contention.
- Write arbitration: same rule with an independent wr_prio bit.
- Concurrent classes: one reader plus one writer are both granted in the same cycle.
- RAM drive (combinational, same cycle T):
  - ram_raddr = {granted read addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'0}.
  - ram_we = granted write strobe, else 0.
  - ram_din = granted write data.
  - ram_waddr = granted write line address.
  - With no grant, ram_raddr/ram_waddr/ram_din hold the last driven values (registered copies); ram_we = 0.
- Response pipeline:
  - At T, register: rsp_owner (which requester read), rsp_pend = 1, fwd_hit, fwd_strb, fwd_data.
  - fwd_hit = read and write both granted at T && same line address.
  - At T+1: rsp_valid_owner = 1 and rsp_valid_other = 0.
  - At T+1, per byte b: rsp_rdata = fwd_hit && fwd_strb[b] ? fwd_data[b] : ram_dout[b].
  - Both rsp_rdata outputs carry the same merged value; only the owner's valid is asserted.
- Ordering:
  - A write accepted at T is visible to any read accepted at T (via forwarding) or at T+1 onward (via the RAM).
  - A read accepted at T never sees a write accepted at T+1.
- Throughput: one read and one write per cycle sustained; no bubbles.
- Reset (rst high at a posedge):
  - Clears rd_prio, wr_prio, rsp_pend, fwd_hit and the registered ram addr/din copies to 0.
  - While rst = 1: req_ready_0/1 = 0, ram_we = 0, rsp_valid_0/1 = 0.
  - A read accepted in the cycle before reset asserts produces no response.
  - RAM contents are not touched.
- Unaligned addresses: low OFF_BITS are silently ignored; no error reported.

Test Plan:
1. Reset, then R0 reads 0x0040 alone -> ready_0=1 at T; ram_raddr=0x0040; rsp_valid_0=1 at T+1 with RAM line 1 data; rsp_valid_1=0.
2. Both read every cycle for 4 cycles after reset -> grants alternate 0,1,0,1; each rsp_valid arrives 1 cycle after its grant; no idle cycle.
3. Same cycle: R0 writes 0x0080 with strb=0x...000F and data bytes 0-3=0xDEADBEEF, R1 reads 0x0080 (old line all 0x11) -> both ready; rsp_rdata_1 bytes 0-3=EF,BE,AD,DE, bytes 4-63=0x11.
4. Both write every cycle -> wr_prio alternates; ram_we never asserted for both requesters in one cycle; a readback of each line matches the winner order (later write wins).
5. R1 issues a read at T, rst asserted at T+1 -> no rsp_valid_1; ready_0/1=0 and ram_we=0 during rst; first post-reset contention grants requester 0.
6. Read at 0x00C7 (unaligned) -> ram_raddr=0x00C0; response returns line 3.
